// File: rtl/weight_buffer_if.sv
// Write-side handshake bundle for weight_buffer.
// The producer is the master: it offers a word with wr_valid/wr_data and
// holds it until the loader raises wr_ready. The word moves on the edge
// where both are high.
`timescale 1ns/1ps
interface weight_buffer_if #(
   parameter int WORD_WIDTH = 32
);
   logic                  wr_valid;
   logic [WORD_WIDTH-1:0] wr_data;
   logic                  wr_ready;

   modport master (
      output wr_valid,
      output wr_data,
      input  wr_ready
   );

   modport slave (
      input  wr_valid,
      input  wr_data,
      output wr_ready
   );
endinterface : weight_buffer_if

// File: rtl/weight_buffer.sv
// Double-buffered weight loader.
// Words stream into a shadow matrix, MSB-first. The ALU sees only the
// active matrix, which is replaced in one step on a swap once the shadow
// set is complete, so the ALU never sees a half-written set.
`timescale 1ns/1ps
module weight_buffer #(
   parameter  int MP_BITWIDTH = 8,
   parameter  int WEIGHT_SIZE = 4,
   parameter  int WORD_WIDTH  = 32,
   localparam int MAT_W       = MP_BITWIDTH * WEIGHT_SIZE * WEIGHT_SIZE,
   localparam int WORDS       = MAT_W / WORD_WIDTH,
   localparam int CNT_W       = $clog2(WORDS) + 1
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   weight_buffer_if.slave       wr_if,
   input  logic                 swap_i,
   input  logic                 clear_i,
   output logic [MAT_W-1:0]     weight_matrix_o,
   output logic                 weight_valid_o,
   output logic                 shadow_full_o,
   output logic [CNT_W-1:0]     load_count_o
);

   // Fill level of the shadow set: the count alone decides the state.
   // The enum keeps the FSM readable.
   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_FILLING = 2'd1,
      ST_FULL    = 2'd2
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   count_q;
   logic [MAT_W-1:0]   shadow_q;
   logic [MAT_W-1:0]   shadow_d;
   logic [MAT_W-1:0]   active_q;
   logic               valid_q;

   logic               accept;
   logic               last_word;

   // Ready is combinational so that clear_i blocks a same-cycle write.
   // A cleared word is then neither stored nor counted.
   assign wr_if.wr_ready = (state_q != ST_FULL) && !clear_i;
   assign accept         = wr_if.wr_valid && wr_if.wr_ready;
   assign last_word      = (count_q == CNT_W'(WORDS - 1));

   // Each shadow word slot loads only when its index matches the count.
   // Word 0 lands in the most significant slot, which matches the ALU's
   // MSB-first slicing of FC and conv weights.
   for (genvar gi = 0; gi < WORDS; gi++) begin : g_slot
      assign shadow_d[MAT_W-1-gi*WORD_WIDTH -: WORD_WIDTH] =
         (accept && (count_q == CNT_W'(gi))) ? wr_if.wr_data
                                             : shadow_q[MAT_W-1-gi*WORD_WIDTH -: WORD_WIDTH];
   end

   // Load/swap FSM. Priority is clear, then swap (FULL only), then write.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= ST_EMPTY;
         count_q  <= '0;
         shadow_q <= '0;
         active_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         if (clear_i) begin
            // Stale shadow bits may remain. They are unreachable until
            // they are overwritten by a complete new set.
            state_q <= ST_EMPTY;
            count_q <= '0;
         end else begin
            case (state_q)
               ST_EMPTY, ST_FILLING: begin
                  // A swap here is ignored: there is no partial promotion.
                  if (accept) begin
                     count_q <= count_q + CNT_W'(1);
                     state_q <= last_word ? ST_FULL : ST_FILLING;
                  end
               end
               ST_FULL: begin
                  if (swap_i) begin
                     active_q <= shadow_q;
                     valid_q  <= 1'b1;
                     count_q  <= '0;
                     state_q  <= ST_EMPTY;
                  end
               end
               default: begin
                  state_q <= ST_EMPTY;
                  count_q <= '0;
               end
            endcase
         end
      end
   end

   assign weight_matrix_o = active_q;
   assign weight_valid_o  = valid_q;
   assign shadow_full_o   = (state_q == ST_FULL);
   assign load_count_o    = count_q;

endmodule : weight_buffer

// File: tb/tb_weight_buffer.sv
// Self-checking bench for weight_buffer.
// A queue-based model holds the shadow words and the active matrix.
// Every cycle the bench compares the DUT against this model, and it
// checks the directed scenarios against literal constants.
`timescale 1ns/1ps
module tb_weight_buffer;

   localparam int WORDS = 4;

   logic          clk;
   logic          rst_n;
   logic          swap;
   logic          clear;
   logic [127:0]  weight_matrix;
   logic          weight_valid;
   logic          shadow_full;
   logic [2:0]    load_count;

   int tests;
   int fails;

   // Reference model: the shadow set as a word queue, plus the active matrix.
   logic [31:0]   m_words[$];
   logic [127:0]  m_active;
   bit            m_valid;

   weight_buffer_if #(.WORD_WIDTH(32)) bus ();

   weight_buffer #(
      .MP_BITWIDTH (8),
      .WEIGHT_SIZE (4),
      .WORD_WIDTH  (32)
   ) dut (
      .clk_i           (clk),
      .rst_n_i         (rst_n),
      .wr_if           (bus),
      .swap_i          (swap),
      .clear_i         (clear),
      .weight_matrix_o (weight_matrix),
      .weight_valid_o  (weight_valid),
      .shadow_full_o   (shadow_full),
      .load_count_o    (load_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always terminates.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] pack_words();
      logic [127:0] m;
      m = '0;
      foreach (m_words[i]) m = {m[95:0], m_words[i]};
      return m;
   endfunction

   task automatic check_regs();
      chk("matrix", weight_matrix, m_active);
      chk("valid", 128'(weight_valid), 128'(m_valid));
      chk("full", 128'(shadow_full), 128'(m_words.size() == WORDS));
      chk("count", 128'(load_count), 128'(m_words.size()));
   endtask

   // One clock cycle. Inputs are driven at the negedge and ready is checked
   // before the edge. The model then advances, and the registered outputs
   // are checked 1ns after the edge.
   task automatic step(input bit v, input logic [31:0] d, input bit sw, input bit cl);
      bit exp_ready;
      @(negedge clk);
      bus.wr_valid = v;
      bus.wr_data  = d;
      swap         = sw;
      clear        = cl;
      #1;
      exp_ready = (m_words.size() < WORDS) && !cl;
      chk("ready", 128'(bus.wr_ready), 128'(exp_ready));
      if (cl) begin
         m_words.delete();
      end else if (m_words.size() == WORDS && sw) begin
         m_active = pack_words();
         m_valid  = 1'b1;
         m_words.delete();
      end else if (exp_ready && v) begin
         m_words.push_back(d);
      end
      @(posedge clk);
      #1;
      check_regs();
      $display("[TB] t=%0t v=%0d d=%h swap=%0d clear=%0d -> count=%0d full=%0d valid=%0d",
               $time, v, d, sw, cl, load_count, shadow_full, weight_valid);
   endtask

   initial begin
      tests        = 0;
      fails        = 0;
      m_active     = '0;
      m_valid      = 1'b0;
      rst_n        = 1'b0;
      bus.wr_valid = 1'b0;
      bus.wr_data  = '0;
      swap         = 1'b0;
      clear        = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_matrix", weight_matrix, 128'h0);
      chk("rst_valid", 128'(weight_valid), 128'h0);
      chk("rst_full", 128'(shadow_full), 128'h0);
      chk("rst_count", 128'(load_count), 128'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_ready", 128'(bus.wr_ready), 128'h1);

      // Basic load of four words, then swap
      step(1, 32'h01020304, 0, 0);
      step(1, 32'h05060708, 0, 0);
      step(1, 32'h090A0B0C, 0, 0);
      step(1, 32'h0D0E0F10, 0, 0);
      chk("tp_ready_full", 128'(bus.wr_ready), 128'h0);
      step(0, 32'h0, 0, 0);
      chk("tp_ready_wait", 128'(bus.wr_ready), 128'h0);
      step(0, 32'h0, 1, 0);
      chk("tp_matrix", weight_matrix, 128'h0102030405060708090A0B0C0D0E0F10);
      chk("tp_valid", 128'(weight_valid), 128'h1);
      chk("tp_ready_after", 128'(bus.wr_ready), 128'h1);

      // Backpressure while FULL
      for (int i = 0; i < 4; i++) step(1, 32'hCAFE0000 + 32'(i), 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(1, 32'hDEADBEEF, 0, 0);
         chk("bp_ready", 128'(bus.wr_ready), 128'h0);
         chk("bp_count", 128'(load_count), 128'h4);
      end
      step(1, 32'hDEADBEEF, 1, 0);
      chk("bp_matrix", weight_matrix, 128'hCAFE0000_CAFE0001_CAFE0002_CAFE0003);
      step(1, 32'hDEADBEEF, 0, 0);
      chk("bp_word0_count", 128'(load_count), 128'h1);
      for (int i = 0; i < 3; i++) step(1, 32'h12345678, 0, 0);
      step(0, 32'h0, 1, 0);
      chk("bp_word0_matrix", weight_matrix, 128'hDEADBEEF_12345678_12345678_12345678);

      // Double buffering
      for (int i = 0; i < 4; i++) step(1, 32'h11111111, 0, 0);
      step(0, 32'h0, 1, 0);
      chk("db_first", weight_matrix, {4{32'h11111111}});
      for (int i = 0; i < 4; i++) begin
         step(1, 32'h22222222, 0, 0);
         chk("db_hold", weight_matrix, {4{32'h11111111}});
      end
      step(0, 32'h0, 0, 0);
      chk("db_hold_full", weight_matrix, {4{32'h11111111}});
      step(0, 32'h0, 1, 0);
      chk("db_swapped", weight_matrix, {4{32'h22222222}});

      // Early swap is ignored; clear beats a same-cycle write
      step(1, 32'h55555555, 0, 0);
      step(1, 32'h55555555, 0, 0);
      step(0, 32'h0, 1, 0);
      chk("early_count", 128'(load_count), 128'h2);
      chk("early_matrix", weight_matrix, {4{32'h22222222}});
      step(1, 32'h77777777, 0, 1);
      chk("clr_count", 128'(load_count), 128'h0);
      for (int i = 0; i < 4; i++) step(1, 32'hAAAAAAAA, 0, 0);
      step(0, 32'h0, 1, 0);
      chk("clr_matrix", weight_matrix, {4{32'hAAAAAAAA}});

      // Clear beats a swap in FULL
      for (int i = 0; i < 4; i++) step(1, 32'h33333333, 0, 0);
      step(0, 32'h0, 1, 1);
      chk("clrswap_matrix", weight_matrix, {4{32'hAAAAAAAA}});
      chk("clrswap_count", 128'(load_count), 128'h0);
      chk("clrswap_valid", 128'(weight_valid), 128'h1);

      // Last write and swap in the same cycle: the swap waits one edge
      for (int i = 0; i < 3; i++) step(1, 32'h44444444, 0, 0);
      step(1, 32'h44444444, 1, 0);
      chk("same_full", 128'(shadow_full), 128'h1);
      chk("same_matrix", weight_matrix, {4{32'hAAAAAAAA}});
      step(0, 32'h0, 1, 0);
      chk("same_swapped", weight_matrix, {4{32'h44444444}});

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0,
              $urandom_range(0, 19) == 0);
      end

      // Asynchronous reset mid-load after a valid swap
      step(0, 32'h0, 0, 1);
      for (int i = 0; i < 4; i++) step(1, 32'h66666666, 0, 0);
      step(0, 32'h0, 1, 0);
      for (int i = 0; i < 3; i++) step(1, 32'h99999999, 0, 0);
      chk("ar_pre_count", 128'(load_count), 128'h3);
      chk("ar_pre_valid", 128'(weight_valid), 128'h1);
      bus.wr_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_matrix", weight_matrix, 128'h0);
      chk("ar_valid", 128'(weight_valid), 128'h0);
      chk("ar_count", 128'(load_count), 128'h0);
      chk("ar_full", 128'(shadow_full), 128'h0);
      m_words.delete();
      m_active = '0;
      m_valid  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 32'hBBBBBBBB, 0, 0);
      step(0, 32'h0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_weight_buffer
